shared_register_arbiter: RTL

- Round-robin arbiter and load sequencer for one shared N-bit parallel-load register.
- M requesters compete to write the register. The block grants one requester at a time, drives the register's load and data-select internally, and returns a one-cycle ack per completed write.
- The block sits between several producer blocks and a single shared configuration/data register. The register contents are always visible on Q.

---
 rtl/shared_register_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/shared_register_arbiter.sv
// Round-robin arbiter and load sequencer for one shared parallel-load register.
// Grants one requester per three-cycle IDLE -> LOAD -> RELEASE transaction.
module shared_register_arbiter #(
  parameter  int N = 4,
  parameter  int M = 4,
  localparam int W = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M-1:0]   req,
  input  logic [M*N-1:0] wdata,
  output logic [M-1:0]   ack,
  output logic [W-1:0]   owner,
  output logic           busy,
  output logic [N-1:0]   Q
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RELEASE
  } state_t;

  state_t       state;
  logic [W-1:0] rr_ptr;
  logic [W-1:0] winner;
  logic [W:0]   sum;
  logic         found;
  logic [N-1:0] odata;

  // first set request at or after rr_ptr, wrapping modulo M
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    sum    = '0;
    for (int k = 0; k < M; k++) begin
      sum = {1'b0, rr_ptr} + (W+1)'(k);
      if (sum >= (W+1)'(M))
        sum = sum - (W+1)'(M);
      if (!found && req[sum[W-1:0]]) begin
        winner = sum[W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    odata = '0;
    for (int i = 0; i < M; i++)
      if (owner == W'(i))
        odata = wdata[i*N +: N];
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < M; i++)
      ack[i] = (state == RELEASE) && (owner == W'(i));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      Q      <= '0;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            owner <= winner;
            state <= LOAD;
          end
        end
        LOAD: begin
          // a withdrawn request aborts without touching Q or rr_ptr
          if (req[owner]) begin
            Q     <= odata;
            state <= RELEASE;
          end else begin
            state <= IDLE;
          end
        end
        RELEASE: begin
          rr_ptr <= (owner == W'(M-1)) ? '0 : owner + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
